// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave, oversampled in the clk domain. A command byte
// {rw, ..., addr} is followed by a burst of data words that either write the
// register bank or read it back on MISO, with auto-incrementing address.
module spi_reg_slave #(
   parameter int unsigned DATA_W   = 8,
   parameter int unsigned NUM_REGS = 16,
   parameter int unsigned ADDR_W   = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       SCLK,
   input  logic                       SSEL,
   input  logic                       MOSI,
   output logic                       MISO,
   output logic [NUM_REGS*DATA_W-1:0] regs_flat,
   output logic                       wr_stb,
   output logic [ADDR_W-1:0]          wr_addr,
   output logic [DATA_W-1:0]          wr_data,
   output logic                       busy
);

   localparam int unsigned CntW = $clog2(DATA_W);

   typedef enum logic [1:0] {StIdle, StCmd, StData} state_e;

   // [0] first sync stage, [1] second sync stage, [2] one-clk delayed copy
   logic [2:0] sclk_sync_q, sclk_sync_d;
   logic [1:0] ssel_sync_q, ssel_sync_d;
   logic [1:0] mosi_sync_q, mosi_sync_d;
   // Marks when the SSEL synchroniser holds real samples after reset
   logic [1:0] settle_q, settle_d;
   logic       arm_q, arm_d;

   state_e                     state_q, state_d;
   logic [CntW-1:0]            bit_cnt_q, bit_cnt_d;
   logic [DATA_W-2:0]          rx_shift_q, rx_shift_d;
   logic [DATA_W-1:0]          tx_shift_q, tx_shift_d;
   logic [ADDR_W-1:0]          addr_q, addr_d;
   logic                       cmd_wr_q, cmd_wr_d;
   logic [NUM_REGS*DATA_W-1:0] regs_q, regs_d;
   logic                       wr_stb_q, wr_stb_d;
   logic [ADDR_W-1:0]          wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]          wr_data_q, wr_data_d;

   logic              rise, fall, ssel_inact, mosi_s;
   logic              word_done, addr_ok;
   logic [DATA_W-1:0] rx_word;
   logic [ADDR_W-1:0] addr_inc;

   // Out-of-range addresses read as zero
   function automatic logic [DATA_W-1:0] reg_rd(input logic [ADDR_W-1:0]          a,
                                                input logic [NUM_REGS*DATA_W-1:0] bank);
      if (32'(a) < NUM_REGS) begin
         return bank[32'(a)*DATA_W +: DATA_W];
      end
      return '0;
   endfunction

   assign rise       = sclk_sync_q[1] & ~sclk_sync_q[2];
   assign fall       = ~sclk_sync_q[1] & sclk_sync_q[2];
   assign ssel_inact = ssel_sync_q[1];
   assign mosi_s     = mosi_sync_q[1];
   assign rx_word    = {rx_shift_q, mosi_s};
   assign word_done  = rise && (bit_cnt_q == CntW'(DATA_W-1));
   assign addr_ok    = 32'(addr_q) < NUM_REGS;
   assign addr_inc   = (addr_q == ADDR_W'(NUM_REGS-1)) ? '0 : addr_q + ADDR_W'(1);

   // Next state of the input synchronisers and the post-reset settle tracker
   always_comb begin
      sclk_sync_d = {sclk_sync_q[1:0], SCLK};
      ssel_sync_d = {ssel_sync_q[0], SSEL};
      mosi_sync_d = {mosi_sync_q[0], MOSI};
      settle_d    = {settle_q[0], 1'b1};
   end

   // Synchroniser registers; SSEL resets to inactive so busy starts low
   always_ff @(posedge clk) begin
      if (rst) begin
         sclk_sync_q <= '0;
         ssel_sync_q <= '1;
         mosi_sync_q <= '0;
         settle_q    <= '0;
      end else begin
         sclk_sync_q <= sclk_sync_d;
         ssel_sync_q <= ssel_sync_d;
         mosi_sync_q <= mosi_sync_d;
         settle_q    <= settle_d;
      end
   end

   // Frame FSM: command decode, write burst and read burst next-state logic
   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      rx_shift_d = rx_shift_q;
      tx_shift_d = tx_shift_q;
      addr_d     = addr_q;
      cmd_wr_d   = cmd_wr_q;
      regs_d     = regs_q;
      wr_stb_d   = 1'b0;
      wr_addr_d  = wr_addr_q;
      wr_data_d  = wr_data_q;
      // A frame may only start once SSEL has been seen idle since reset
      arm_d      = arm_q | (ssel_inact & settle_q[1]);

      unique case (state_q)
         StIdle: begin
            bit_cnt_d  = '0;
            tx_shift_d = '0;
            if (!ssel_inact && arm_q) begin
               state_d = StCmd;
            end
         end
         StCmd: begin
            if (rise) begin
               rx_shift_d = rx_word[DATA_W-2:0];
               bit_cnt_d  = bit_cnt_q + CntW'(1);
               if (word_done) begin
                  bit_cnt_d = '0;
                  cmd_wr_d  = rx_word[DATA_W-1];
                  addr_d    = rx_word[ADDR_W-1:0];
                  state_d   = StData;
                  if (!rx_word[DATA_W-1]) begin
                     tx_shift_d = reg_rd(rx_word[ADDR_W-1:0], regs_q);
                  end
               end
            end
         end
         StData: begin
            if (rise) begin
               rx_shift_d = rx_word[DATA_W-2:0];
               bit_cnt_d  = bit_cnt_q + CntW'(1);
               if (word_done) begin
                  bit_cnt_d = '0;
                  addr_d    = addr_inc;
                  if (cmd_wr_q && addr_ok) begin
                     regs_d[32'(addr_q)*DATA_W +: DATA_W] = rx_word;
                     wr_stb_d  = 1'b1;
                     wr_addr_d = addr_q;
                     wr_data_d = rx_word;
                  end
               end
            end else if (fall && !cmd_wr_q) begin
               // The fall trailing a word boundary presents the next word's MSB
               // instead of shifting, so the master never sees it clipped.
               if (bit_cnt_q == '0) begin
                  tx_shift_d = reg_rd(addr_q, regs_q);
               end else begin
                  tx_shift_d = {tx_shift_q[DATA_W-2:0], 1'b0};
               end
            end
         end
         default: state_d = StIdle;
      endcase

      // Deselect aborts the frame and drops any partial word
      if (ssel_inact) begin
         state_d    = StIdle;
         bit_cnt_d  = '0;
         tx_shift_d = '0;
      end
   end

   // Frame FSM and register bank state
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         bit_cnt_q  <= '0;
         rx_shift_q <= '0;
         tx_shift_q <= '0;
         addr_q     <= '0;
         cmd_wr_q   <= 1'b0;
         regs_q     <= '0;
         wr_stb_q   <= 1'b0;
         wr_addr_q  <= '0;
         wr_data_q  <= '0;
         arm_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         rx_shift_q <= rx_shift_d;
         tx_shift_q <= tx_shift_d;
         addr_q     <= addr_d;
         cmd_wr_q   <= cmd_wr_d;
         regs_q     <= regs_d;
         wr_stb_q   <= wr_stb_d;
         wr_addr_q  <= wr_addr_d;
         wr_data_q  <= wr_data_d;
         arm_q      <= arm_d;
      end
   end

   assign MISO      = tx_shift_q[DATA_W-1];
   assign regs_flat = regs_q;
   assign wr_stb    = wr_stb_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign busy      = ~ssel_sync_q[1];

endmodule

// File: tb/tb_spi_reg_slave.sv
// Directed bench for spi_reg_slave: an SPI master model with jittered SCLK at
// about clk/4, a write-strobe scoreboard and a MISO byte scoreboard.
`timescale 1ns/100ps
module tb_spi_reg_slave;

   localparam int unsigned DW = 8;
   localparam int unsigned NR = 16;
   localparam int unsigned AW = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic            sclk;
   logic            ssel;
   logic            mosi;
   logic            miso;
   logic [NR*DW-1:0] regs_flat;
   logic            wr_stb;
   logic [AW-1:0]   wr_addr;
   logic [DW-1:0]   wr_data;
   logic            busy;

   int checks  = 0;
   int errors  = 0;
   int stb_cnt = 0;

   logic [AW+DW-1:0] exp_wr_q[$];
   logic [DW-1:0]    exp_rx_q[$];
   logic [DW-1:0]    model [NR];
   logic [DW-1:0]    dbuf  [NR];

   spi_reg_slave #(
      .DATA_W   (DW),
      .NUM_REGS (NR),
      .ADDR_W   (AW)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .SCLK      (sclk),
      .SSEL      (ssel),
      .MOSI      (mosi),
      .MISO      (miso),
      .regs_flat (regs_flat),
      .wr_stb    (wr_stb),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [NR*DW-1:0] obs, input logic [NR*DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NR*DW-1:0] model_flat();
      logic [NR*DW-1:0] f;
      for (int i = 0; i < int'(NR); i++) f[i*DW +: DW] = model[i];
      return f;
   endfunction

   // Write-strobe scoreboard
   always @(negedge clk) begin
      logic [AW+DW-1:0] e;
      if (wr_stb === 1'b1) begin
         stb_cnt++;
         chk("stb_expected", NR*DW'(exp_wr_q.size() != 0), NR*DW'(1));
         if (exp_wr_q.size() != 0) begin
            e = exp_wr_q.pop_front();
            chk("wr_addr", NR*DW'(wr_addr), NR*DW'(e[AW+DW-1:DW]));
            chk("wr_data", NR*DW'(wr_data), NR*DW'(e[DW-1:0]));
            chk("reg_on_stb", NR*DW'(regs_flat[32'(e[AW+DW-1:DW])*DW +: DW]),
                NR*DW'(e[DW-1:0]));
         end
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   task automatic half(input real base);
      real d;
      d = base + real'($urandom_range(0, 40)) / 10.0;
      #(d);
   endtask

   // MSB first; MISO sampled mid-high, clear of the oversampled update windows
   task automatic spi_bits(input logic [DW-1:0] b, input int n, output logic [DW-1:0] r);
      r = '0;
      for (int i = DW-1; i > int'(DW)-1-n; i--) begin
         mosi = b[i];
         half(20.0);
         sclk = 1'b1;
         #14;
         r[i] = miso;
         half(6.0);
         sclk = 1'b0;
      end
   endtask

   task automatic xfer(input logic [DW-1:0] b, output logic [DW-1:0] r);
      #($urandom_range(0, 15));
      spi_bits(b, DW, r);
   endtask

   task automatic sel();
      ssel = 1'b0;
      half(30.0);
   endtask

   task automatic desel();
      half(10.0);
      ssel = 1'b1;
      repeat (4) @(posedge clk);
      #1;
   endtask

   task automatic wr_frame(input logic [AW-1:0] a0, input int n);
      logic [DW-1:0] r;
      logic [AW-1:0] a;
      a = a0;
      sel();
      xfer({1'b1, 3'b000, a0}, r);
      chk("wr_cmd_miso", NR*DW'(r), '0);
      for (int i = 0; i < n; i++) begin
         exp_wr_q.push_back({a, dbuf[i]});
         model[a] = dbuf[i];
         xfer(dbuf[i], r);
         a = (a == AW'(NR-1)) ? '0 : a + AW'(1);
      end
      desel();
      chk("wr_drained", NR*DW'(exp_wr_q.size()), '0);
   endtask

   task automatic rd_frame(input logic [AW-1:0] a0, input int n);
      logic [DW-1:0] r;
      logic [AW-1:0] a;
      int            s0;
      s0 = stb_cnt;
      a  = a0;
      for (int i = 0; i < n; i++) begin
         exp_rx_q.push_back(model[a]);
         a = (a == AW'(NR-1)) ? '0 : a + AW'(1);
      end
      sel();
      xfer({1'b0, 3'b000, a0}, r);
      chk("rd_cmd_miso", NR*DW'(r), '0);
      for (int i = 0; i < n; i++) begin
         xfer(8'(i) ^ 8'hA5, r);
         chk("rd_byte", NR*DW'(r), NR*DW'(exp_rx_q.pop_front()));
      end
      desel();
      chk("rd_no_stb", NR*DW'(stb_cnt), NR*DW'(s0));
      chk("rd_regs", regs_flat, model_flat());
   endtask

   initial begin
      logic [DW-1:0] r;
      int            s0;
      rst  = 1'b1;
      sclk = 1'b0;
      ssel = 1'b1;
      mosi = 1'b0;
      for (int i = 0; i < int'(NR); i++) model[i] = '0;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_regs", regs_flat, '0);
      chk("rst_miso", NR*DW'(miso), '0);
      chk("rst_stb", NR*DW'(wr_stb), '0);
      chk("rst_waddr", NR*DW'(wr_addr), '0);
      chk("rst_wdata", NR*DW'(wr_data), '0);
      chk("rst_busy", NR*DW'(busy), '0);
      @(negedge clk);
      rst = 1'b0;
      repeat (5) @(posedge clk);

      // Write burst
      dbuf[0] = 8'h11; dbuf[1] = 8'h22; dbuf[2] = 8'h33;
      wr_frame(4'd2, 3);
      chk("burst_stb_cnt", NR*DW'(stb_cnt), NR*DW'(3));
      chk("burst_regs", regs_flat, model_flat());

      // Readback
      rd_frame(4'd3, 2);

      // Wrap from the top register to register 0
      dbuf[0] = 8'hAA; dbuf[1] = 8'hBB;
      wr_frame(4'd15, 2);
      chk("wrap_regs", regs_flat, model_flat());

      // Abort inside a data word
      s0 = stb_cnt;
      sel();
      xfer(8'h85, r);
      spi_bits(8'hFF, 5, r);
      ssel = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("abort_busy", NR*DW'(busy), '0);
      chk("abort_miso", NR*DW'(miso), '0);
      repeat (4) @(posedge clk);
      #1;
      chk("abort_no_stb", NR*DW'(stb_cnt), NR*DW'(s0));
      chk("abort_regs", regs_flat, model_flat());

      // Reset in the middle of a write data byte
      sel();
      xfer(8'h81, r);
      spi_bits(8'h5A, 4, r);
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int i = 0; i < int'(NR); i++) model[i] = '0;
      chk("mrst_regs", regs_flat, '0);
      chk("mrst_miso", NR*DW'(miso), '0);
      chk("mrst_stb", NR*DW'(wr_stb), '0);
      chk("mrst_waddr", NR*DW'(wr_addr), '0);
      chk("mrst_wdata", NR*DW'(wr_data), '0);
      chk("mrst_busy", NR*DW'(busy), '0);
      @(negedge clk);
      rst = 1'b0;
      s0  = stb_cnt;
      // SSEL still low: the rest of this frame must be ignored
      xfer(8'hC3, r);
      xfer(8'h3C, r);
      desel();
      chk("mrst_ignored", NR*DW'(stb_cnt), NR*DW'(s0));
      chk("mrst_regs_after", regs_flat, '0);
      dbuf[0] = 8'h5A;
      wr_frame(4'd1, 1);
      chk("mrst_reframe", regs_flat, model_flat());

      // Full-bank write then read at about clk/4 with jitter
      for (int i = 0; i < int'(NR); i++) dbuf[i] = 8'($urandom_range(0, 255));
      wr_frame(4'd0, NR);
      chk("stress_regs", regs_flat, model_flat());
      rd_frame(4'd0, NR);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/spi_reg_slave.md
Name: spi_reg_slave

Overview:
- SPI slave (mode 0, MSB first) running entirely in the system clock domain; SCLK, SSEL and MOSI are oversampled and edge-detected.
- Decodes a command byte followed by a burst of data bytes.
- Writes to, or reads back from, a parametrised bank of DATA_W-bit registers.
- Register contents drive the demoscene parameter inputs, exported as one flat bus.

Parameters:
- DATA_W, 8, width of each register and of each SPI data word.
- NUM_REGS, 16, number of registers; must be <= 2**ADDR_W.
- ADDR_W, 4, address width; must be <= DATA_W-1.

Ports:
- clk  input  1  system clock; must be >= 4x SCLK frequency.
- rst  input  1  synchronous, active-high reset.
- SCLK  input  1  SPI clock, asynchronous to clk; idles low.
- SSEL  input  1  SPI select, active low, asynchronous.
- MOSI  input  1  SPI data in, asynchronous.
- MISO  output  1  SPI data out; driven, never tristated.
- regs_flat  output  NUM_REGS*DATA_W  register bank; reg i at bits [i*DATA_W +: DATA_W].
- wr_stb  output  1  one-clk pulse per completed write data word.
- wr_addr  output  ADDR_W  address of the last write.
- wr_data  output  DATA_W  data of the last write.
- busy  output  1  high while SSEL is synchronised-active.

Behaviour:
- Synchronisers and edges:
  - SCLK, SSEL, MOSI each pass through 2-flop synchronisers.
  - rise = sync SCLK 0->1; fall = sync SCLK 1->0, both computed from sync SCLK and a one-clk delayed copy.
- Reset (rst=1 at posedge clk): every register in regs_flat = 0, MISO = 0, wr_stb = 0, wr_addr = 0, wr_data = 0, busy = 0, state = IDLE, counters cleared. Reset mid-frame aborts the frame; the block stays in IDLE until SSEL is seen inactive then active again.
- State machine IDLE -> CMD -> DATA:
  - IDLE: MISO = 0; bit_cnt = 0. Sync SSEL going low -> CMD.
  - CMD: each rise shifts MOSI into rx_shift (LSB in) and increments bit_cnt.
    - When bit_cnt reaches DATA_W: cmd_wr = bit[DATA_W-1] (1 = write, 0 = read), addr = bits[ADDR_W-1:0], bit_cnt = 0, go to DATA.
    - On read, tx_shift loads reg[addr] in that same clk and MISO presents its MSB by the next clk, i.e. before the first rise of the data word.
  - DATA, write: each completed word (DATA_W rises) writes reg[addr] on the following clk.
    - wr_stb pulses for that clk, with wr_addr = addr and wr_data = word.
    - Then addr increments.
  - DATA, read: on each fall, tx_shift shifts left and MISO = new MSB.
    - After DATA_W rises, addr increments and tx_shift reloads from the new reg[addr].
    - MOSI is ignored; no writes occur.
- Address wrap: addr == NUM_REGS-1 increments to 0.
  - Command address >= NUM_REGS: writes are dropped (no wr_stb) and reads return 0.
  - Increment still wraps at 2**ADDR_W back to 0, and valid registers are accessed once reached.
- SSEL deasserted (sync high) in any state: return to IDLE in the next clk, discard any partial word with no write and no strobe, MISO = 0.
- MISO during CMD = 0. busy = sync SSEL active.
- regs_flat updates on the clk of wr_stb; a read in the same frame sees the updated value.

Test Plan:
- Write burst: SSEL low, send 0x82, 0x11, 0x22, 0x33, SSEL high -> reg2 = 0x11, reg3 = 0x22, reg4 = 0x33; exactly 3 wr_stb pulses with wr_addr 2, 3, 4; other registers 0.
- Readback: after the write burst, send 0x03 then 2 dummy bytes -> MISO bytes 0x22, 0x33; no wr_stb; registers unchanged.
- Wrap: send 0x8F, 0xAA, 0xBB -> reg15 = 0xAA, reg0 = 0xBB.
- Abort: send 0x85 then 5 bits of 0xFF, SSEL high -> no wr_stb, reg5 unchanged, MISO = 0, busy = 0 within 3 clk.
- Reset mid-frame: assert rst during a write data byte -> all registers 0, outputs at reset values; the following full frame 0x81, 0x5A after SSEL toggles gives reg1 = 0x5A.
- Ratio stress: SCLK = clk/4 with asynchronous phase jitter, 16-byte write then 16-byte read of all registers -> readback matches the written data exactly.
